// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store,
// one transaction outstanding, with fetch anti-starvation and a timeout.
//
// Ports:
//   clk, rstn            clock; asynchronous active-high reset
//   if_req/if_addr       fetch request, held until if_gnt
//   if_gnt, if_rvalid    fetch grant / response pulses, if_rdata
//   d_req/d_we/d_addr    data request, held until d_gnt
//   d_wdata/d_wstrb      store data and byte strobes
//   d_gnt, d_rvalid      data grant / response pulses, d_rdata
//   mem_req, mem_we      issue pulse and registered transaction fields
//   mem_addr/wdata/wstrb
//   mem_rvalid/rdata     memory completion
//   mem_abort, err       timeout pulses
// Optional: define PERF_CNT_EN to add perf_if_grants, perf_d_grants,
//   perf_conflicts and perf_timeouts 32-bit event counters.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            mem_abort,
  output logic            err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]     perf_if_grants,
  output logic [31:0]     perf_d_grants,
  output logic [31:0]     perf_conflicts,
  output logic [31:0]     perf_timeouts
`endif
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state;
  logic          owner;
  logic [WW-1:0] fetch_wait;
  logic [TW-1:0] tcnt;

  logic any_req;
  logic both_req;
  logic fetch_win;
  logic wait_max;

  always_comb begin
    any_req   = if_req | d_req;
    both_req  = if_req & d_req;
    wait_max  = (fetch_wait == WW'(MAX_WAIT));
    fetch_win = if_req & (~d_req | wait_max);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      fetch_wait <= '0;
      tcnt       <= '0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      mem_abort  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      mem_req   <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_abort <= 1'b0;
      err       <= 1'b0;

      // Only an IDLE-cycle loss counts toward starvation.
      if (!if_req) begin
        fetch_wait <= '0;
      end else if (state == IDLE) begin
        if (fetch_win)
          fetch_wait <= '0;
        else if (!wait_max)
          fetch_wait <= fetch_wait + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (any_req) begin
            state   <= BUSY;
            mem_req <= 1'b1;
            tcnt    <= '0;
            owner   <= ~fetch_win;
            if (fetch_win) begin
              if_gnt    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_wstrb <= '0;
            end else begin
              d_gnt     <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_wstrb;
            end
          end
        end
        BUSY: begin
          if (mem_rvalid) begin
            state <= IDLE;
            if (owner) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_we ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            mem_abort <= 1'b1;
            err       <= 1'b1;
            if (owner) begin
              d_rvalid <= 1'b1;
              d_rdata  <= DW'(32'hDEADBEEF);
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= DW'(32'hDEADBEEF);
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      perf_if_grants <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
      perf_timeouts  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        if (fetch_win)
          perf_if_grants <= perf_if_grants + 1'b1;
        else
          perf_d_grants <= perf_d_grants + 1'b1;
      end
      if (state == IDLE && both_req)
        perf_conflicts <= perf_conflicts + 1'b1;
      if (state == BUSY && !mem_rvalid &&
          tcnt == TW'(TIMEOUT - 1))
        perf_timeouts <= perf_timeouts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected
// grant/response events, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_abort, err;
`ifdef PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_d_grants;
  logic [31:0] perf_conflicts, perf_timeouts;
`endif

  mem_port_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .mem_abort (mem_abort),
    .err       (err)
`ifdef PERF_CNT_EN
    ,
    .perf_if_grants(perf_if_grants),
    .perf_d_grants (perf_d_grants),
    .perf_conflicts(perf_conflicts),
    .perf_timeouts (perf_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          rsp;
    logic        ig, dg, we;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        irv, drv;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void exp_gnt(int c, bit isd, logic we,
                                  logic [31:0] a,
                                  logic [31:0] wd,
                                  logic [3:0] ws);
    exp_t e;
    e.cyc = c; e.rsp = 1'b0;
    e.ig = !isd; e.dg = isd; e.we = we;
    e.addr = a; e.wdata = wd; e.wstrb = ws;
    e.irv = 1'b0; e.drv = 1'b0; e.rd = '0; e.er = 1'b0;
    sb.push_back(e);
  endfunction

  function automatic void exp_rsp(int c, bit isd,
                                  logic [31:0] rd, bit er);
    exp_t e;
    e.cyc = c; e.rsp = 1'b1;
    e.ig = 1'b0; e.dg = 1'b0; e.we = 1'b0;
    e.addr = '0; e.wdata = '0; e.wstrb = '0;
    e.irv = !isd; e.drv = isd; e.rd = rd; e.er = er;
    sb.push_back(e);
  endfunction

  exp_t m_e;
  bit   m_ok;

  always @(negedge clk) begin
    if (!rstn && (if_gnt | d_gnt | mem_req | if_rvalid |
                  d_rvalid | err | mem_abort)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse cyc=%0d ig=%b dg=%b mr=%b irv=%b drv=%b err=%b ab=%b",
                 cyc, if_gnt, d_gnt, mem_req, if_rvalid,
                 d_rvalid, err, mem_abort);
      end else begin
        m_e = sb.pop_front();
        if (!m_e.rsp) begin
          m_ok = (cyc == m_e.cyc) && (if_gnt == m_e.ig) &&
                 (d_gnt == m_e.dg) && mem_req &&
                 !if_rvalid && !d_rvalid && !err &&
                 !mem_abort && (mem_we == m_e.we) &&
                 (mem_addr == m_e.addr) &&
                 (!m_e.dg || (mem_wdata == m_e.wdata &&
                              mem_wstrb == m_e.wstrb));
          if (!m_ok) begin
            miscompares++;
            $display("FAIL grant: got cyc=%0d ig=%b dg=%b mr=%b we=%b addr=%h wd=%h ws=%h, want cyc=%0d ig=%b dg=%b we=%b addr=%h wd=%h ws=%h",
                     cyc, if_gnt, d_gnt, mem_req, mem_we,
                     mem_addr, mem_wdata, mem_wstrb, m_e.cyc,
                     m_e.ig, m_e.dg, m_e.we, m_e.addr,
                     m_e.wdata, m_e.wstrb);
          end
        end else begin
          m_ok = (cyc == m_e.cyc) && !if_gnt && !d_gnt &&
                 !mem_req && (if_rvalid == m_e.irv) &&
                 (d_rvalid == m_e.drv) && (err == m_e.er) &&
                 (mem_abort == m_e.er) &&
                 (m_e.irv ? (if_rdata == m_e.rd)
                          : (d_rdata == m_e.rd));
          if (!m_ok) begin
            miscompares++;
            $display("FAIL response: got cyc=%0d irv=%b drv=%b ird=%h drd=%h err=%b ab=%b, want cyc=%0d irv=%b drv=%b rd=%h err=%b",
                     cyc, if_rvalid, d_rvalid, if_rdata,
                     d_rdata, err, mem_abort, m_e.cyc,
                     m_e.irv, m_e.drv, m_e.rd, m_e.er);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic reset_outs(string tag);
    chk({tag, "_pulses"},
        {25'b0, if_gnt, d_gnt, mem_req, if_rvalid,
         d_rvalid, err, mem_abort}, 32'h0);
    chk({tag, "_we_strb"}, {27'b0, mem_we, mem_wstrb}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  int c0;
  int g;

  initial begin
    repeat (3) tick();
    reset_outs("rst");
    rstn = 1'b0;
    tick();

    // fetch only
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    exp_gnt(c0 + 1, 0, 1'b0, 32'h100, '0, '0);
    wait_cyc(c0 + 1); if_req = 1'b0;
    wait_cyc(c0 + 2);
    mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
    exp_rsp(c0 + 3, 0, 32'h00500093, 0);
    wait_cyc(c0 + 3); mem_rvalid = 1'b0;
    wait_cyc(c0 + 5);

    // starvation: 2-cycle memory, data always pending
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    d_wdata = '0; d_wstrb = '0;
    if_req = 1'b1; if_addr = 32'h108;
    for (int k = 0; k < 5; k++) begin
      g = c0 + 1 + k * 4;
      exp_gnt(g, k < 4, 1'b0,
              (k < 4) ? 32'h300 : 32'h108, '0, '0);
      wait_cyc(g);
      if (k == 4) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      wait_cyc(g + 2);
      mem_rvalid = 1'b1; mem_rdata = 32'hA0 + k;
      exp_rsp(g + 3, k < 4, 32'hA0 + k, 0);
      wait_cyc(g + 3); mem_rvalid = 1'b0;
    end
    wait_cyc(cyc + 2);

    // simultaneous store + fetch; data wins after wait reset
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200;
    d_wdata = 32'hCAFEF00D; d_wstrb = 4'hF;
    exp_gnt(c0 + 1, 1, 1'b1, 32'h200, 32'hCAFEF00D, 4'hF);
    wait_cyc(c0 + 1); d_req = 1'b0; d_we = 1'b0;
    wait_cyc(c0 + 2);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    exp_rsp(c0 + 3, 1, 32'h0, 0);
    exp_gnt(c0 + 4, 0, 1'b0, 32'h104, '0, '0);
    wait_cyc(c0 + 3); mem_rvalid = 1'b0;
    wait_cyc(c0 + 4); if_req = 1'b0;
    wait_cyc(c0 + 5);
    mem_rvalid = 1'b1; mem_rdata = 32'h00000013;
    exp_rsp(c0 + 6, 0, 32'h00000013, 0);
    wait_cyc(c0 + 6); mem_rvalid = 1'b0;
    wait_cyc(c0 + 8);

    // timeout on a load, then a late completion
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    d_wdata = '0; d_wstrb = '0;
    exp_gnt(c0 + 1, 1, 1'b0, 32'h400, '0, '0);
    exp_rsp(c0 + 17, 1, 32'hDEADBEEF, 1);
    wait_cyc(c0 + 1); d_req = 1'b0;
    wait_cyc(c0 + 19);
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    wait_cyc(c0 + 20); mem_rvalid = 1'b0;
    wait_cyc(c0 + 24);

    // reset during BUSY
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h500;
    exp_gnt(c0 + 1, 0, 1'b0, 32'h500, '0, '0);
    wait_cyc(c0 + 1); if_req = 1'b0;
    wait_cyc(c0 + 2); rstn = 1'b1;
    #1 reset_outs("midrst");
    wait_cyc(c0 + 3); rstn = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    wait_cyc(c0 + 4); mem_rvalid = 1'b0;
    wait_cyc(c0 + 5);
    if_req = 1'b1; if_addr = 32'h504;
    exp_gnt(c0 + 6, 0, 1'b0, 32'h504, '0, '0);
    wait_cyc(c0 + 6); if_req = 1'b0;
    wait_cyc(c0 + 7);
    mem_rvalid = 1'b1; mem_rdata = 32'h00100073;
    exp_rsp(c0 + 8, 0, 32'h00100073, 0);
    wait_cyc(c0 + 8); mem_rvalid = 1'b0;
    wait_cyc(c0 + 10);

    // back-to-back loads, 1-cycle memory
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    for (int k = 0; k < 3; k++) begin
      g = c0 + 1 + k * 3;
      exp_gnt(g, 1, 1'b0, 32'h600 + 4 * k, '0, '0);
      wait_cyc(g);
      if (k < 2) d_addr = 32'h600 + 4 * (k + 1);
      else d_req = 1'b0;
      wait_cyc(g + 1);
      mem_rvalid = 1'b1; mem_rdata = 32'hB0 + k;
      exp_rsp(g + 2, 1, 32'hB0 + k, 0);
      wait_cyc(g + 2); mem_rvalid = 1'b0;
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    wait_cyc(cyc + 4);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_events: got %0d left, expected 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
